ro_puf_engine: RTL and testbench
================================

Name: ro_puf_engine

Overview:
- Parametrised ring-oscillator PUF evaluation engine; next generation of the fixed 16-RO / 8-bit-response PUF top.
- Counts rising edges on NUM_RO external oscillator outputs over a programmable window, then derives RESP_BITS response bits from challenge-selected RO pairs.
- Sits between the oscillator array and the challenge/response interface; adds counter saturation handling, tie detection and abort-on-disable.

Parameters:
- NUM_RO, 16, number of oscillator inputs; power of two, ≥4.
- IDX_W, $clog2(NUM_RO), RO index width (derived, not overridden).
- CHALL_WIDTH, 2*IDX_W, challenge width: low half = base A, high half = base B.
- RESP_BITS, 8, response width; 1..NUM_RO.
- CNT_WIDTH, 12, per-RO edge counter width.
- WINDOW_CYCLES, 256, measurement window in clk cycles; ≥1.

Ports:
- clk  in  1  system clock.
- sys_rst_pos  in  1  asynchronous, active-high reset.
- en  in  1  level start/hold; 0 aborts or releases.
- chall_in  in  CHALL_WIDTH  challenge; latched when a measurement starts.
- ro_in  in  NUM_RO  oscillator outputs; asynchronous to clk; each bit's high and low phases are ≥2 clk cycles.
- response  out  RESP_BITS  response; bit i from pair i.
- ready  out  1  response valid.
- tie_mask  out  RESP_BITS  present only with PUF_TIE_MASK_EN.

Behaviour:
- Reset (async, any state): state=IDLE, response=0, ready=0, all counters=0, latched challenge=0, tie_mask=0.
- Each ro_in bit passes through a 2-flop synchroniser and rising-edge detect, which run continuously. A counter increments only in MEASURE and saturates at 2^CNT_WIDTH-1; it never wraps.
- FSM IDLE -> CLEAR -> MEASURE -> COMPARE -> DONE:
- IDLE: at the edge E0 where en=1, latch chall_in, clear response, go to CLEAR.
- CLEAR: zero all counters and the window counter; next edge E1 -> MEASURE.
- MEASURE: count at edges E2..E(WINDOW_CYCLES+1), exactly WINDOW_CYCLES edges; the last one -> COMPARE.
- COMPARE: one bit per cycle, i = 0..RESP_BITS-1; after the last bit -> DONE.
- DONE: ready=1 and response held while en=1; en=0 -> IDLE with ready=0 and response held until the next start.
- Latency: ready first reads 1 after edge E0+WINDOW_CYCLES+RESP_BITS+1.
- Abort: en=0 in CLEAR, MEASURE or COMPARE -> IDLE at that edge; response=0, ready=0.
- A restart needs only en=1 in IDLE; en held high after DONE does not retrigger.
- Pair selection, all arithmetic mod NUM_RO:
- a_i = A + i.
- b_i = B + 2i + 1.
- If a_i == b_i, then b_i = a_i + 1.
- Bit rule: response[i] = (cnt[a_i] > cnt[b_i]). On equality, including both counters saturated, the bit is 0 and tie_i=1.
- chall_in changes outside the latch edge have no effect.

Optional Feature:
- PUF_TIE_MASK_EN defined: tie_mask port exists. tie_mask[i]=tie_i is written in COMPARE alongside response[i], follows the same reset/clear/abort rules as response, and is valid when ready=1.
- Macro undefined: no port and no tie storage; the bit rule is unchanged.

Decomposition:
- Shared package puf_pkg holds:
  - state enum (IDLE, CLEAR, MEASURE, COMPARE, DONE);
  - pair-index function (a_i/b_i with collision bump);
  - default parameter constants.
- Sub-module ro_edge_counter (synchroniser, edge detect, saturating counter with clear/enable), instantiated NUM_RO times.
- The FSM and comparator stay in ro_puf_engine.

Test Plan:
- Defaults; bench toggles ro_in[k] with period 4+k clk cycles; en=1 after 10 ns reset, chall_in=8'h01 -> ready after 265 cycles, response=8'hFF, tie_mask=8'h00.
- Same stimulus with chall_in=8'hc1 (A=1, B=12, collision bump at i=4) -> response=8'hF3.
- All ro_in with identical period 8 and phase, chall_in=8'h2c -> response=8'h00, tie_mask=8'hFF.
- CNT_WIDTH=3, period 4+k, chall_in=8'h01 -> all counters saturate at 7 -> response=8'h00, tie_mask=8'hFF, no wrap.
- Drop en mid-MEASURE (cycle 100) -> ready=0, response=0 next edge. Re-raise en -> full latency again and response matches the first test (8'hFF).
- Pulse sys_rst_pos during COMPARE -> outputs 0 immediately (asynchronous). Re-run chall_in=8'h01 -> response=8'hFF.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF engine: FSM state
// encoding, challenge-to-pair index mapping and default configuration.
package puf_pkg;

  localparam int DEF_NUM_RO        = 16;
  localparam int DEF_RESP_BITS     = 8;
  localparam int DEF_CNT_WIDTH     = 12;
  localparam int DEF_WINDOW_CYCLES = 256;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MEASURE,
    COMPARE,
    DONE
  } puf_state_e;

  // First oscillator of pair i: walks up from base A one step per bit.
  function automatic int pair_a(input int base_a, input int i, input int num_ro);
    return (base_a + i) % num_ro;
  endfunction

  // Second oscillator of pair i: odd stride from base B, bumped by one when it
  // lands on the same oscillator as pair_a so a pair never compares with itself.
  function automatic int pair_b(input int base_a, input int base_b, input int i,
                                input int num_ro);
    int a;
    int b;
    a = (base_a + i) % num_ro;
    b = (base_b + 2 * i + 1) % num_ro;
    if (b == a) b = (a + 1) % num_ro;
    return b;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Per-oscillator edge counter: 2-flop synchroniser, rising-edge detect and a
// saturating event counter with synchronous clear and count enable.
module ro_edge_counter #(
  parameter int CNT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ro,
  input  logic                 clr,
  input  logic                 cnt_en,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;
  logic rise;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Stage p0/p1: metastability synchroniser; p2: previous level for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= ro;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~prev_p2;

  // Counter holds at all-ones rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt_en && rise) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/ro_puf_engine.sv
// Ring-oscillator PUF engine: counts oscillator edges over a fixed window and
// compares challenge-selected pairs. Define PUF_TIE_MASK_EN to add the tie_mask port.
module ro_puf_engine
  import puf_pkg::*;
#(
  parameter  int NUM_RO        = DEF_NUM_RO,
  localparam int IDX_W         = $clog2(NUM_RO),
  parameter  int CHALL_WIDTH   = 2 * IDX_W,
  parameter  int RESP_BITS     = DEF_RESP_BITS,
  parameter  int CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter  int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
  input  logic                   clk,
  input  logic                   sys_rst_pos,
  input  logic                   en,
  input  logic [CHALL_WIDTH-1:0] chall_in,
  input  logic [NUM_RO-1:0]      ro_in,
  output logic [RESP_BITS-1:0]   response,
  output logic                   ready
`ifdef PUF_TIE_MASK_EN
  ,
  output logic [RESP_BITS-1:0]   tie_mask
`endif
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam int BIT_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(RESP_BITS - 1);

  puf_state_e state;
  puf_state_e state_nxt;

  logic [CHALL_WIDTH-1:0] chall_q;
  logic [WIN_W-1:0]       win_cnt;
  logic [BIT_W-1:0]       bit_idx;
  logic [CNT_WIDTH-1:0]   cnt [NUM_RO];
  logic                   cnt_clr;
  logic                   cnt_en;
  logic                   start;
  logic                   abort;
  logic                   cmp_wr;
  logic [IDX_W-1:0]       sel_a;
  logic [IDX_W-1:0]       sel_b;
  logic                   bit_gt;

  assign cnt_clr = (state == CLEAR);
  assign cnt_en  = (state == MEASURE);

  for (genvar g = 0; g < NUM_RO; g++) begin : g_ro
    ro_edge_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk    (clk),
      .rst    (sys_rst_pos),
      .ro     (ro_in[g]),
      .clr    (cnt_clr),
      .cnt_en (cnt_en),
      .cnt    (cnt[g])
    );
  end

  always_ff @(posedge clk or posedge sys_rst_pos) begin
    if (sys_rst_pos) state <= IDLE;
    else             state <= state_nxt;
  end

  // Dropping en anywhere before DONE abandons the run and clears the outputs
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    abort     = 1'b0;
    cmp_wr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_nxt = CLEAR;
          start     = 1'b1;
        end
      end
      CLEAR: begin
        if (!en) abort = 1'b1;
        else     state_nxt = MEASURE;
      end
      MEASURE: begin
        if (!en)                      abort = 1'b1;
        else if (win_cnt == WIN_LAST) state_nxt = COMPARE;
      end
      COMPARE: begin
        if (!en) begin
          abort = 1'b1;
        end else begin
          cmp_wr = 1'b1;
          if (bit_idx == BIT_LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        if (!en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  assign ready = (state == DONE);

  always_ff @(posedge clk or posedge sys_rst_pos) begin
    if (sys_rst_pos) begin
      chall_q <= '0;
      win_cnt <= '0;
      bit_idx <= '0;
    end else begin
      if (start) chall_q <= chall_in;
      if (state == CLEAR)        win_cnt <= '0;
      else if (state == MEASURE) win_cnt <= win_cnt + WIN_W'(1);
      if (state == CLEAR) bit_idx <= '0;
      else if (cmp_wr)    bit_idx <= bit_idx + BIT_W'(1);
    end
  end

  // Pair selection and comparison, one response bit per COMPARE cycle
  always_comb begin
    sel_a = IDX_W'(pair_a(int'(chall_q[IDX_W-1:0]), int'(bit_idx), NUM_RO));
    sel_b = IDX_W'(pair_b(int'(chall_q[IDX_W-1:0]),
                          int'(chall_q[CHALL_WIDTH-1:IDX_W]),
                          int'(bit_idx), NUM_RO));
  end

  assign bit_gt = cnt[sel_a] > cnt[sel_b];

  always_ff @(posedge clk or posedge sys_rst_pos) begin
    if (sys_rst_pos) begin
      response <= '0;
    end else if (start || abort) begin
      response <= '0;
    end else if (cmp_wr) begin
      for (int i = 0; i < RESP_BITS; i++) begin
        if (int'(bit_idx) == i) response[i] <= bit_gt;
      end
    end
  end

`ifdef PUF_TIE_MASK_EN
  logic                 bit_tie;
  logic [RESP_BITS-1:0] tie_q;

  assign bit_tie = cnt[sel_a] == cnt[sel_b];

  always_ff @(posedge clk or posedge sys_rst_pos) begin
    if (sys_rst_pos) begin
      tie_q <= '0;
    end else if (start || abort) begin
      tie_q <= '0;
    end else if (cmp_wr) begin
      for (int i = 0; i < RESP_BITS; i++) begin
        if (int'(bit_idx) == i) tie_q[i] <= bit_tie;
      end
    end
  end

  assign tie_mask = tie_q;
`endif

endmodule

// File: tb/tb_ro_puf_engine.sv
// Bench for ro_puf_engine: ladder, identical and random oscillator patterns
// checked against an edge-counting reference, plus abort and reset scenarios.
`timescale 1ns/1ps
module tb_ro_puf_engine;

  localparam int NRO    = 16;
  localparam int RB     = 8;
  localparam int WIN    = 256;
  localparam int CW     = 12;
  localparam int CW_SAT = 3;
  localparam int LAT    = WIN + RB + 1;

  logic           clk = 1'b0;
  logic           sys_rst_pos;
  logic           en;
  logic [7:0]     chall_in;
  logic [NRO-1:0] ro_in = '0;
  logic [RB-1:0]  response, response_s;
  logic           ready, ready_s;
`ifdef PUF_TIE_MASK_EN
  logic [RB-1:0]  tie_mask, tie_mask_s;
`endif

  int checks = 0;
  int errors = 0;
  int per [NRO];
  int pha [NRO];
  int tcnt = 0;
  int cyc = 0;
  logic [NRO-1:0] hist [0:65535];

  always #5 clk = ~clk;

  ro_puf_engine #(
    .NUM_RO(NRO), .RESP_BITS(RB), .CNT_WIDTH(CW), .WINDOW_CYCLES(WIN)
  ) dut (
    .clk(clk), .sys_rst_pos(sys_rst_pos), .en(en), .chall_in(chall_in),
    .ro_in(ro_in), .response(response), .ready(ready)
`ifdef PUF_TIE_MASK_EN
    , .tie_mask(tie_mask)
`endif
  );

  ro_puf_engine #(
    .NUM_RO(NRO), .RESP_BITS(RB), .CNT_WIDTH(CW_SAT), .WINDOW_CYCLES(WIN)
  ) dut_sat (
    .clk(clk), .sys_rst_pos(sys_rst_pos), .en(en), .chall_in(chall_in),
    .ro_in(ro_in), .response(response_s), .ready(ready_s)
`ifdef PUF_TIE_MASK_EN
    , .tie_mask(tie_mask_s)
`endif
  );

  // Oscillator model: bit k is high for the first half of each period
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < NRO; k++) ro_in[k] = ((tcnt + pha[k]) % per[k]) < (per[k] / 2);
    tcnt++;
  end

  always @(posedge clk) begin
    hist[cyc[15:0]] <= ro_in;
    cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference: a rise seen by the synchroniser two edges after it is sampled is
  // counted if that lands inside edges E0+2 .. E0+WIN+1; counts saturate.
  function automatic void model(input logic [7:0] ch, input int e0, input int cw,
                                output logic [RB-1:0] resp, output logic [RB-1:0] tie);
    int cnt [NRO];
    int cmax;
    int a, b;
    logic [NRO-1:0] cur, old;
    cmax = (1 << cw) - 1;
    foreach (cnt[k]) cnt[k] = 0;
    for (int n = e0 + 2; n <= e0 + WIN + 1; n++) begin
      cur = hist[16'(n - 2)];
      old = hist[16'(n - 3)];
      for (int k = 0; k < NRO; k++)
        if (cur[k] && !old[k] && cnt[k] < cmax) cnt[k]++;
    end
    for (int i = 0; i < RB; i++) begin
      a = (int'(ch[3:0]) + i) % NRO;
      b = (int'(ch[7:4]) + 2 * i + 1) % NRO;
      if (a == b) b = (a + 1) % NRO;
      resp[i] = cnt[a] > cnt[b];
      tie[i]  = cnt[a] == cnt[b];
    end
  endfunction

  task automatic set_ladder();
    for (int k = 0; k < NRO; k++) begin per[k] = 4 + k; pha[k] = 0; end
  endtask

  // Starts a measurement, scrambles chall_in afterwards and waits (bounded) for ready
  task automatic run(input logic [7:0] ch, output int e0, output int edges,
                     output logic [RB-1:0] r1);
    @(negedge clk);
    chall_in = ch;
    en = 1'b1;
    e0 = cyc;
    @(negedge clk);
    edges = 1;
    r1 = response;
    chall_in = ~ch;
    while (ready !== 1'b1 && edges < 4 * LAT) begin
      @(negedge clk);
      edges++;
      chall_in = 8'($urandom);
    end
  endtask

  task automatic stop();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    en = 1'b0;
    chall_in = '0;
    sys_rst_pos = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (response !== 8'h00) begin errors++; $display("FAIL reset_resp got %h want 00", response); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (response_s !== 8'h00) begin errors++; $display("FAIL reset_resp_sat got %h want 00", response_s); end
`ifdef PUF_TIE_MASK_EN
    checks++; if (tie_mask !== 8'h00) begin errors++; $display("FAIL reset_tie got %h want 00", tie_mask); end
`endif
    sys_rst_pos = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", ready); end
  endtask

  task automatic test_ladder(input logic [7:0] ch, input logic [RB-1:0] exp);
    int e0, edges;
    logic [RB-1:0] r1, m_resp, m_tie, s_resp, s_tie;
    set_ladder();
    repeat (4) @(negedge clk);
    run(ch, e0, edges, r1);
    model(ch, e0, CW, m_resp, m_tie);
    model(ch, e0, CW_SAT, s_resp, s_tie);
    checks++; if (edges - 1 != LAT) begin errors++; $display("FAIL ladder_latency ch=%h got %0d want %0d", ch, edges - 1, LAT); end
    checks++; if (response !== exp) begin errors++; $display("FAIL ladder_resp ch=%h got %h want %h", ch, response, exp); end
    checks++; if (response !== m_resp) begin errors++; $display("FAIL ladder_model ch=%h got %h want %h", ch, response, m_resp); end
    checks++; if (ready_s !== 1'b1 || response_s !== s_resp) begin errors++; $display("FAIL ladder_sat ch=%h got %b/%h want 1/%h", ch, ready_s, response_s, s_resp); end
`ifdef PUF_TIE_MASK_EN
    checks++; if (tie_mask !== 8'h00 || tie_mask !== m_tie) begin errors++; $display("FAIL ladder_tie ch=%h got %h want %h", ch, tie_mask, m_tie); end
`endif
    stop();
  endtask

  task automatic test_identical();
    int e0, edges;
    logic [RB-1:0] r1;
    for (int k = 0; k < NRO; k++) begin per[k] = 8; pha[k] = 0; end
    repeat (4) @(negedge clk);
    run(8'h2c, e0, edges, r1);
    checks++; if (edges - 1 != LAT) begin errors++; $display("FAIL ident_latency got %0d want %0d", edges - 1, LAT); end
    checks++; if (response !== 8'h00) begin errors++; $display("FAIL ident_resp got %h want 00", response); end
    checks++; if (response_s !== 8'h00) begin errors++; $display("FAIL ident_resp_sat got %h want 00", response_s); end
`ifdef PUF_TIE_MASK_EN
    checks++; if (tie_mask !== 8'hFF) begin errors++; $display("FAIL ident_tie got %h want FF", tie_mask); end
`endif
    stop();
  endtask

  task automatic test_saturation();
    int e0, edges;
    logic [RB-1:0] r1;
    set_ladder();
    repeat (4) @(negedge clk);
    run(8'h01, e0, edges, r1);
    checks++; if (ready_s !== 1'b1) begin errors++; $display("FAIL sat_ready got %b want 1", ready_s); end
    checks++; if (response_s !== 8'h00) begin errors++; $display("FAIL sat_resp got %h want 00", response_s); end
    checks++; if (response !== 8'hFF) begin errors++; $display("FAIL sat_wide_resp got %h want FF", response); end
`ifdef PUF_TIE_MASK_EN
    checks++; if (tie_mask_s !== 8'hFF) begin errors++; $display("FAIL sat_tie got %h want FF", tie_mask_s); end
`endif
    stop();
  endtask

  task automatic test_abort();
    int e0, edges;
    logic [RB-1:0] r1;
    set_ladder();
    repeat (4) @(negedge clk);
    @(negedge clk); chall_in = 8'h01; en = 1'b1;
    repeat (100) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b0 || response !== 8'h00) begin errors++; $display("FAIL abort_meas got %b/%h want 0/00", ready, response); end
    repeat (WIN + 20) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_meas_stays got %b want 0", ready); end
    @(negedge clk); chall_in = 8'h01; en = 1'b1;
    repeat (WIN + 6) @(negedge clk);
    checks++; if (response !== 8'h0F) begin errors++; $display("FAIL compare_partial got %h want 0F", response); end
    en = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b0 || response !== 8'h00) begin errors++; $display("FAIL abort_cmp got %b/%h want 0/00", ready, response); end
    run(8'h01, e0, edges, r1);
    checks++; if (edges - 1 != LAT) begin errors++; $display("FAIL abort_rerun_latency got %0d want %0d", edges - 1, LAT); end
    checks++; if (response !== 8'hFF) begin errors++; $display("FAIL abort_rerun_resp got %h want FF", response); end
    stop();
  endtask

  task automatic test_async_reset();
    int e0, edges;
    logic [RB-1:0] r1;
    set_ladder();
    repeat (4) @(negedge clk);
    @(negedge clk); chall_in = 8'h01; en = 1'b1;
    repeat (WIN + 6) @(negedge clk);
    checks++; if (response !== 8'h0F) begin errors++; $display("FAIL rst_pre_partial got %h want 0F", response); end
    #1 sys_rst_pos = 1'b1;
    #1;
    checks++; if (response !== 8'h00 || ready !== 1'b0) begin errors++; $display("FAIL async_rst got %b/%h want 0/00", ready, response); end
    @(negedge clk);
    en = 1'b0;
    sys_rst_pos = 1'b0;
    repeat (6) @(negedge clk);
    run(8'h01, e0, edges, r1);
    checks++; if (edges - 1 != LAT) begin errors++; $display("FAIL rst_rerun_latency got %0d want %0d", edges - 1, LAT); end
    checks++; if (response !== 8'hFF) begin errors++; $display("FAIL rst_rerun_resp got %h want FF", response); end
    stop();
  endtask

  task automatic test_hold();
    int e0, edges;
    logic [RB-1:0] r1, m_resp, m_tie;
    set_ladder();
    repeat (4) @(negedge clk);
    run(8'h01, e0, edges, r1);
    checks++; if (response !== 8'hFF) begin errors++; $display("FAIL hold_first got %h want FF", response); end
    repeat (30) begin @(negedge clk); chall_in = 8'($urandom); end
    checks++; if (ready !== 1'b1 || response !== 8'hFF) begin errors++; $display("FAIL hold_no_retrigger got %b/%h want 1/FF", ready, response); end
    en = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b0 || response !== 8'hFF) begin errors++; $display("FAIL release got %b/%h want 0/FF", ready, response); end
    repeat (5) @(negedge clk);
    checks++; if (response !== 8'hFF) begin errors++; $display("FAIL idle_hold got %h want FF", response); end
    run(8'hc1, e0, edges, r1);
    model(8'hc1, e0, CW, m_resp, m_tie);
    checks++; if (r1 !== 8'h00) begin errors++; $display("FAIL restart_clear got %h want 00", r1); end
    checks++; if (edges - 1 != LAT) begin errors++; $display("FAIL restart_latency got %0d want %0d", edges - 1, LAT); end
    checks++; if (response !== 8'hF3 || response !== m_resp) begin errors++; $display("FAIL restart_resp got %h want F3/%h", response, m_resp); end
    stop();
  endtask

  task automatic test_random();
    int e0, edges;
    logic [7:0] ch;
    logic [RB-1:0] r1, m_resp, m_tie, s_resp, s_tie;
    for (int k = 0; k < NRO; k++) begin
      per[k] = int'($urandom_range(24, 4));
      pha[k] = int'($urandom_range(per[k] - 1, 0));
    end
    repeat (8) @(negedge clk);
    for (int it = 0; it < 4; it++) begin
      ch = 8'($urandom);
      run(ch, e0, edges, r1);
      model(ch, e0, CW, m_resp, m_tie);
      model(ch, e0, CW_SAT, s_resp, s_tie);
      checks++; if (edges - 1 != LAT) begin errors++; $display("FAIL rand_latency ch=%h got %0d want %0d", ch, edges - 1, LAT); end
      checks++; if (response !== m_resp) begin errors++; $display("FAIL rand_resp ch=%h got %h want %h", ch, response, m_resp); end
      checks++; if (response_s !== s_resp) begin errors++; $display("FAIL rand_resp_sat ch=%h got %h want %h", ch, response_s, s_resp); end
`ifdef PUF_TIE_MASK_EN
      checks++; if (tie_mask !== m_tie) begin errors++; $display("FAIL rand_tie ch=%h got %h want %h", ch, tie_mask, m_tie); end
      checks++; if (tie_mask_s !== s_tie) begin errors++; $display("FAIL rand_tie_sat ch=%h got %h want %h", ch, tie_mask_s, s_tie); end
`endif
      stop();
    end
  endtask

  initial begin
    set_ladder();
    test_reset();
    test_ladder(8'h01, 8'hFF);
    test_ladder(8'hc1, 8'hF3);
    test_identical();
    test_saturation();
    test_abort();
    test_async_reset();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
